ap_call_arbiter: RTL

//  - Shares one ap_ctrl_hs callee (e.g. the os_sift_up sub-function) between NUM_REQ callers inside toplevel.
//  - Round-robin arbitration, ap_start/ap_ready/ap_done sequencing, stable grant index for arg/return muxes.
//  - Callee-side handshakes are the same signals the dataflow module monitors sample, so monitor traces stay valid.

---
 rtl/ap_call_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ap_call_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs callee between NUM_REQ callers.
// Optional watchdog enabled by defining AP_ARB_TIMEOUT_EN.
module ap_call_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [NUM_REQ-1:0] req_start,
    output logic [NUM_REQ-1:0] req_ack,
    output logic [NUM_REQ-1:0] req_done,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               callee_ap_start,
    input  logic               callee_ap_ready,
    input  logic               callee_ap_done,
    output logic               busy,
    output logic               timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("ap_call_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALL = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic               r_gv;
    logic [IDX_W-1:0]   r_idx;
    logic               r_start;
    logic               r_busy;
    logic [IDX_W-1:0]   r_rr;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_next;
    logic [NUM_REQ-1:0] w_sel;
    logic               w_live;
    logic               w_hs;
    logic               w_complete;
    logic               w_expire;
    logic               w_end;

    // First requester at or after the rr pointer, wrapping N-1 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ))
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            if (!w_found && req_start[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_sel  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;

    // ap_done without ap_ready in CALL counts as ready+done.
    assign w_live     = (r_state == S_CALL) || (r_state == S_WAIT);
    assign w_hs       = (r_state == S_CALL) && (callee_ap_ready || callee_ap_done);
    assign w_complete = w_live && callee_ap_done;
    assign w_end      = w_complete || w_expire;

`ifdef AP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // A real completion in the expiry cycle wins over the watchdog.
    assign w_expire = w_live && !w_complete &&
                      (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_live || w_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_expire)
                r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_done  <= '0;
            r_gv    <= 1'b0;
            r_idx   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_rr    <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_pick;
                        r_gv    <= 1'b1;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_CALL;
                    end
                end
                S_CALL, S_WAIT: begin
                    if (w_hs) begin
                        r_start <= 1'b0;
                        r_ack   <= w_sel;
                        r_state <= S_WAIT;
                    end
                    if (w_end) begin
                        r_start <= 1'b0;
                        r_done  <= w_sel;
                        r_gv    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_rr    <= w_next;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack         = r_ack;
    assign req_done        = r_done;
    assign grant_valid     = r_gv;
    assign grant_idx       = r_idx;
    assign callee_ap_start = r_start;
    assign busy            = r_busy;

endmodule
